// File: rtl/mcu_core_pkg.sv
// Shared definitions for the mcu_core command processor: opcodes, FSM state
// encodings and error-flag bit masks.
package mcu_core_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_DIV   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_READ  = 4'd7,
    OP_LOADI = 4'd8,
    OP_MOD   = 4'd9
  } opcode_e;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Error-flag masks for the per-result error register
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;

endpackage

// File: rtl/mcu_core_div.sv
// Unsigned restoring divider, one quotient bit per cycle, DATA_W cycles.
// done is high during the last iteration cycle; quotient/remainder then show
// the final values so the caller can capture them on that same edge.
module mcu_core_div #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [DATA_W:0]   shifted, diff;
  logic              ge;

  // One restoring step: shift next dividend bit into the partial remainder, try subtract
  always_comb begin
    shifted   = {rem_q, quo_q[DATA_W-1]};
    diff      = shifted - {1'b0, dvs_q};
    ge        = ~diff[DATA_W];
    remainder = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quotient  = {quo_q[DATA_W-2:0], ge};
  end

  assign done = busy && (cnt == CW'(1));

  // Iteration state; reset aborts any division in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(DATA_W);
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (busy) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt   <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mcu_core.sv
// Single-issue command processor over a 2**ADDR_W x DATA_W register file.
// FSM: IDLE -> EXEC -> (DIV) -> DONE -> IDLE. Define MCU_CORE_MUL_EN to build
// the multiplier for op 2; without it op 2 is reported as illegal.
module mcu_core
  import mcu_core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err_illegal,
  output logic              err_div0
);
  localparam int DEPTH = 2**ADDR_W;

  state_t            state;
  logic [DATA_W-1:0] rf [DEPTH];
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] sa_q, sb_q, dst_q;
  logic [DATA_W-1:0] imm_q, out_q;
  logic [1:0]        err_q;

  logic [DATA_W-1:0] opa, opb, alu_res, div_q, div_r, div_res;
  logic [1:0]        alu_err;
  logic              alu_wr, go_div, div_busy, div_done;

  // Operands are read from the file before any write of this command lands
  assign opa     = rf[sa_q];
  assign opb     = rf[sb_q];
  assign div_res = (op_q == OP_DIV) ? div_q : div_r;

  assign in_ready    = reset && (state == ST_IDLE);
  assign out_valid   = reset && (state == ST_DONE);
  assign out_data    = out_q;
  assign err_illegal = |(err_q & ERR_ILLEGAL);
  assign err_div0    = |(err_q & ERR_DIV0);

  // Single-cycle decode/execute; divide ops with a nonzero divisor hand off to the divider
  always_comb begin
    alu_res = '0;
    alu_err = ERR_NONE;
    alu_wr  = 1'b0;
    go_div  = 1'b0;
    case (op_q)
      OP_ADD:   begin alu_res = opa + opb; alu_wr = 1'b1; end
      OP_SUB:   begin alu_res = opa - opb; alu_wr = 1'b1; end
`ifdef MCU_CORE_MUL_EN
      OP_MUL:   begin alu_res = opa * opb; alu_wr = 1'b1; end
`endif
      OP_AND:   begin alu_res = opa & opb; alu_wr = 1'b1; end
      OP_OR:    begin alu_res = opa | opb; alu_wr = 1'b1; end
      OP_XOR:   begin alu_res = opa ^ opb; alu_wr = 1'b1; end
      OP_READ:  alu_res = opa;
      OP_LOADI: begin alu_res = imm_q; alu_wr = 1'b1; end
      OP_DIV, OP_MOD: begin
        if (opb == '0) begin
          alu_res = (op_q == OP_DIV) ? '1 : opa;
          alu_err = ERR_DIV0;
        end else begin
          go_div = 1'b1;
        end
      end
      default:  alu_err = ERR_ILLEGAL;
    endcase
  end

  mcu_core_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     ((state == ST_EXEC) && go_div),
    .dividend  (opa),
    .divisor   (opb),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Command FSM, result registers and register-file writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      op_q  <= '0;
      sa_q  <= '0;
      sb_q  <= '0;
      dst_q <= '0;
      imm_q <= '0;
      out_q <= '0;
      err_q <= ERR_NONE;
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op_q  <= op;
          sa_q  <= src_a;
          sb_q  <= src_b;
          dst_q <= dst;
          imm_q <= imm;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (go_div) begin
            state <= ST_DIV;
          end else begin
            out_q <= alu_res;
            err_q <= alu_err;
            if (alu_wr) rf[dst_q] <= alu_res;
            state <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            out_q       <= div_res;
            err_q       <= ERR_NONE;
            rf[dst_q]   <= div_res;
            state       <= ST_DONE;
          end else if (!div_busy) begin
            // divider idle without finishing: drop the command rather than hang
            state <= ST_IDLE;
          end
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_core.sv
// Directed bench for mcu_core: the stimulus pushes expected results into a
// scoreboard queue, a monitor pops and compares on each result transfer.
module tb_mcu_core;
  import mcu_core_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0;
  logic [AW-1:0] src_a = '0, src_b = '0, dst = '0;
  logic [DW-1:0] imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          err_illegal, err_div0;

  mcu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .dst(dst), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_illegal(err_illegal), .err_div0(err_div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] data;
    logic          ill;
    logic          dz;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every result transfer must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", out_data, 32'hDEAD_BEEF);
        else begin
          e = sb.pop_front();
          chk({e.name, "_data"}, out_data, e.data);
          chk({e.name, "_err_illegal"}, {31'd0, err_illegal}, {31'd0, e.ill});
          chk({e.name, "_err_div0"}, {31'd0, err_div0}, {31'd0, e.dz});
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk({name, "_in_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Issue one command, push its expectation, check accept-to-out_valid latency
  // (accept edge counts as edge 1).
  task automatic issue(input string name, input logic [3:0] o, input logic [AW-1:0] a, b, d,
                       input logic [DW-1:0] im, input logic [DW-1:0] ed, input logic ill,
                       input logic dz, input int lat);
    exp_t e;
    int n;
    wait_ready(name);
    e.name = name; e.data = ed; e.ill = ill; e.dz = dz;
    sb.push_back(e);
    in_valid = 1'b1; op = o; src_a = a; src_b = b; dst = d; imm = im;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    do begin @(posedge clk); #1; n++; end while (!out_valid && n < 100);
    chk({name, "_latency"}, n, lat);
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input string name, input logic [AW-1:0] r, input logic [DW-1:0] ed);
    issue(name, OP_READ, r, '0, '0, '0, ed, 1'b0, 1'b0, 2);
  endtask

  task automatic ldi(input logic [AW-1:0] r, input logic [DW-1:0] v);
    issue("loadi", OP_LOADI, '0, '0, r, v, v, 1'b0, 1'b0, 2);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_errs", {30'd0, err_illegal, err_div0}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic ALU ops
    ldi(4'd1, 32'd7);
    ldi(4'd2, 32'd5);
    issue("add",  OP_ADD, 4'd1, 4'd2, 4'd3,  '0, 32'd12, 1'b0, 1'b0, 2);
    rd("read_r3", 4'd3, 32'd12);
    issue("sub",  OP_SUB, 4'd2, 4'd1, 4'd7,  '0, 32'hFFFF_FFFE, 1'b0, 1'b0, 2);
    issue("and",  OP_AND, 4'd1, 4'd2, 4'd11, '0, 32'd5, 1'b0, 1'b0, 2);
    issue("or",   OP_OR,  4'd1, 4'd2, 4'd12, '0, 32'd7, 1'b0, 1'b0, 2);
    issue("xor",  OP_XOR, 4'd1, 4'd2, 4'd13, '0, 32'd2, 1'b0, 1'b0, 2);
    rd("read_r7", 4'd7, 32'hFFFF_FFFE);

`ifdef MCU_CORE_MUL_EN
    issue("mul", OP_MUL, 4'd1, 4'd2, 4'd8, '0, 32'd35, 1'b0, 1'b0, 2);
    rd("read_r8", 4'd8, 32'd35);
`else
    issue("mul_off", OP_MUL, 4'd1, 4'd2, 4'd8, '0, 32'd0, 1'b1, 1'b0, 2);
    rd("read_r8", 4'd8, 32'd0);
`endif

    // Illegal opcode leaves the file alone
    issue("illegal12", 4'd12, 4'd1, 4'd2, 4'd3, '0, 32'd0, 1'b1, 1'b0, 2);
    rd("read_r3_after_ill", 4'd3, 32'd12);

    // Full aliasing: R1 = R1 + R1
    issue("alias_add", OP_ADD, 4'd1, 4'd1, 4'd1, '0, 32'd14, 1'b0, 1'b0, 2);
    rd("read_r1_alias", 4'd1, 32'd14);

    // Divide / modulo
    ldi(4'd1, 32'd100);
    ldi(4'd2, 32'd7);
    issue("div", OP_DIV, 4'd1, 4'd2, 4'd4, '0, 32'd14, 1'b0, 1'b0, 34);
    issue("mod", OP_MOD, 4'd1, 4'd2, 4'd5, '0, 32'd2,  1'b0, 1'b0, 34);
    rd("read_r4", 4'd4, 32'd14);
    rd("read_r5", 4'd5, 32'd2);
    ldi(4'd1, 32'hFFFF_FFFF);
    ldi(4'd2, 32'd16);
    issue("div_big", OP_DIV, 4'd1, 4'd2, 4'd14, '0, 32'h0FFF_FFFF, 1'b0, 1'b0, 34);
    issue("mod_big", OP_MOD, 4'd1, 4'd2, 4'd15, '0, 32'd15, 1'b0, 1'b0, 34);

    // Divide by zero
    ldi(4'd1, 32'd9);
    ldi(4'd2, 32'd0);
    issue("div0", OP_DIV, 4'd1, 4'd2, 4'd6, '0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2);
    issue("mod0", OP_MOD, 4'd1, 4'd2, 4'd6, '0, 32'd9, 1'b0, 1'b1, 2);
    rd("read_r6", 4'd6, 32'd0);

    // Back-pressure: result held in DONE, new commands ignored
    out_ready = 1'b0;
    issue("hold", OP_LOADI, '0, '0, 4'd9, 32'h0000_ABCD, 32'h0000_ABCD, 1'b0, 1'b0, 2);
    in_valid = 1'b1; op = OP_LOADI; dst = 4'd9; imm = 32'h1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_data", out_data, 32'h0000_ABCD);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_idle", {31'd0, in_ready}, 32'd1);
    rd("read_r9", 4'd9, 32'h0000_ABCD);

    // Reset in the middle of a division
    ldi(4'd1, 32'd100);
    ldi(4'd2, 32'd7);
    wait_ready("abort");
    in_valid = 1'b1; op = OP_DIV; src_a = 4'd1; src_b = 4'd2; dst = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_data", out_data, 32'd0);
    chk("abort_errs", {30'd0, err_illegal, err_div0}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_release_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    rd("read_r10_abort", 4'd10, 32'd0);
    rd("read_r9_cleared", 4'd9, 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
